// File: rtl/note_seq_pkg.sv
// rtl/note_seq_pkg.sv - shared types and constants for the note sequencer
package note_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_NOTE = 2'd1,
        ST_GAP  = 2'd2
    } state_e;

    localparam int DEF_TICK_CYCLES = 50000;
    localparam int DEF_GAP_TICKS   = 10;

    localparam int PERIOD_W = 32;
    localparam int DUR_W    = 8;
    localparam int ENTRY_W  = PERIOD_W + DUR_W;

endpackage

// File: rtl/tick_divider.sv
// rtl/tick_divider.sv - free-running tick generator with synchronous clear
module tick_divider #(
    parameter int TICK_CYCLES = 50000
) (
    input  logic CLOCK_50,
    input  logic reset,
    input  logic clr,
    output logic tick
);

    localparam int CNT_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tick = (cnt_q == CNT_LAST);

    // next count: clear wins, otherwise wrap on the tick cycle
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clr || tick) begin
            cnt_d = '0;
        end
    end

    // counter register
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/note_sequencer.sv
// rtl/note_sequencer.sv - table-driven note sequencer feeding a waveform generator
module note_sequencer
    import note_seq_pkg::*;
#(
    parameter int NUM_STEPS   = 16,
    parameter int TICK_CYCLES = DEF_TICK_CYCLES,
    parameter int GAP_TICKS   = DEF_GAP_TICKS,
    localparam int ADDR_W     = $clog2(NUM_STEPS)
) (
    input  logic                CLOCK_50,
    input  logic                reset,
    input  logic                start,
    input  logic                stop,
    input  logic                loop_en,
    input  logic                wr_en,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [PERIOD_W-1:0] wr_period,
    input  logic [DUR_W-1:0]    wr_duration,
    output logic [PERIOD_W-1:0] period_cycles,
    output logic                sample_request,
    output logic                busy,
    output logic [ADDR_W-1:0]   step_idx,
    output logic                done
);

    localparam logic [ADDR_W-1:0] LAST_STEP = ADDR_W'(NUM_STEPS - 1);
    localparam int GAP_LAST_I = (GAP_TICKS > 0) ? GAP_TICKS - 1 : 0;
    localparam logic [DUR_W-1:0] GAP_LAST = DUR_W'(GAP_LAST_I);

    // sequence table; contents deliberately survive reset
    logic [PERIOD_W-1:0] period_mem_q [NUM_STEPS];
    logic [DUR_W-1:0]    dur_mem_q    [NUM_STEPS];

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] step_q, step_d;
    logic [DUR_W-1:0]  dur_cnt_q, dur_cnt_d;
    logic              done_q, done_d;

    logic              tick;
    logic              tick_clr;
    logic              enter;
    logic              do_adv;
    logic [ADDR_W-1:0] step_nxt;
    logic [DUR_W-1:0]  cur_dur_last;

    tick_divider #(
        .TICK_CYCLES(TICK_CYCLES)
    ) u_tick (
        .CLOCK_50(CLOCK_50),
        .reset   (reset),
        .clr     (tick_clr),
        .tick    (tick)
    );

    // table writes are accepted only while idle so playback sees a stable table
    always_ff @(posedge CLOCK_50) begin
        if (wr_en && state_q == ST_IDLE) begin
            period_mem_q[wr_addr] <= wr_period;
            dur_mem_q[wr_addr]    <= wr_duration;
        end
    end

    assign step_nxt     = step_q + 1'b1;
    assign cur_dur_last = dur_mem_q[step_q] - 1'b1;

    // next-state: note/gap timing, step advance, stop override
    always_comb begin
        state_d   = state_q;
        step_d    = step_q;
        dur_cnt_d = dur_cnt_q;
        done_d    = 1'b0;
        enter     = 1'b0;
        do_adv    = 1'b0;
        tick_clr  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                tick_clr  = 1'b1;
                dur_cnt_d = '0;
                if (start) begin
                    if (dur_mem_q[0] != '0) begin
                        state_d = ST_NOTE;
                        step_d  = '0;
                        enter   = 1'b1;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            ST_NOTE: begin
                if (tick) begin
                    if (dur_cnt_q == cur_dur_last) begin
                        if (GAP_TICKS == 0) begin
                            do_adv = 1'b1;
                        end else begin
                            state_d = ST_GAP;
                            enter   = 1'b1;
                        end
                    end else begin
                        dur_cnt_d = dur_cnt_q + 1'b1;
                    end
                end
            end
            ST_GAP: begin
                if (tick) begin
                    if (dur_cnt_q == GAP_LAST) begin
                        do_adv = 1'b1;
                    end else begin
                        dur_cnt_d = dur_cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                enter   = 1'b1;
            end
        endcase

        // end of sequence is the last slot or a zero-duration terminator
        if (do_adv) begin
            enter = 1'b1;
            if (step_q == LAST_STEP || dur_mem_q[step_nxt] == '0) begin
                if (loop_en) begin
                    state_d = ST_NOTE;
                    step_d  = '0;
                end else begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end else begin
                state_d = ST_NOTE;
                step_d  = step_nxt;
            end
        end

        if (stop) begin
            state_d = ST_IDLE;
            step_d  = '0;
            done_d  = 1'b0;
            enter   = 1'b1;
        end

        // every state entry restarts both counters so no partial tick carries over
        if (enter) begin
            tick_clr  = 1'b1;
            dur_cnt_d = '0;
        end
    end

    // control registers
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            step_q    <= '0;
            dur_cnt_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            step_q    <= step_d;
            dur_cnt_q <= dur_cnt_d;
            done_q    <= done_d;
        end
    end

    assign period_cycles  = (state_q == ST_NOTE) ? period_mem_q[step_q] : '0;
    assign sample_request = (state_q == ST_NOTE);
    assign busy           = (state_q != ST_IDLE);
    assign step_idx       = step_q;
    assign done           = done_q;

endmodule

// File: tb/tb_note_sequencer.sv
// tb/tb_note_sequencer.sv - directed self-checking bench for note_sequencer
module tb_note_sequencer;

    logic        CLOCK_50 = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        loop_en = 1'b0;
    logic        wr_en = 1'b0;
    logic [3:0]  wr_addr = '0;
    logic [31:0] wr_period = '0;
    logic [7:0]  wr_duration = '0;
    logic [31:0] period_cycles;
    logic        sample_request;
    logic        busy;
    logic [3:0]  step_idx;
    logic        done;

    int checks = 0;
    int errors = 0;

    note_sequencer #(
        .NUM_STEPS  (16),
        .TICK_CYCLES(4),
        .GAP_TICKS  (1)
    ) dut (
        .CLOCK_50      (CLOCK_50),
        .reset         (reset),
        .start         (start),
        .stop          (stop),
        .loop_en       (loop_en),
        .wr_en         (wr_en),
        .wr_addr       (wr_addr),
        .wr_period     (wr_period),
        .wr_duration   (wr_duration),
        .period_cycles (period_cycles),
        .sample_request(sample_request),
        .busy          (busy),
        .step_idx      (step_idx),
        .done          (done)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    task automatic step();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] p, input logic [7:0] d);
        wr_en       = 1'b1;
        wr_addr     = a;
        wr_period   = p;
        wr_duration = d;
        step();
        wr_en = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // n cycles of a fixed output pattern with no done pulse
    task automatic expect_run(input string tag, input int n, input logic [31:0] per,
                              input logic bsy, input logic [3:0] stp);
        for (int i = 0; i < n; i++) begin
            chk({tag, "_period"}, period_cycles, per);
            chk({tag, "_busy"}, 32'(busy), 32'(bsy));
            chk({tag, "_sreq"}, 32'(sample_request), 32'(per != 0));
            chk({tag, "_step"}, 32'(step_idx), 32'(stp));
            chk({tag, "_done"}, 32'(done), 32'd0);
            step();
        end
    endtask

    initial begin
        int cnt;
        bit seen;

        step();
        step();
        chk("rst_period", period_cycles, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_sreq", 32'(sample_request), 32'd0);
        chk("rst_step", 32'(step_idx), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        reset = 1'b0;
        step();

        wr(4'd0, 32'd1000, 8'd2);
        wr(4'd1, 32'd2000, 8'd1);
        wr(4'd2, 32'd0, 8'd0);

        // basic two-note playback
        pulse_start();
        expect_run("s1_n0", 8, 32'd1000, 1'b1, 4'd0);
        expect_run("s1_g0", 4, 32'd0, 1'b1, 4'd0);
        expect_run("s1_n1", 4, 32'd2000, 1'b1, 4'd1);
        expect_run("s1_g1", 4, 32'd0, 1'b1, 4'd1);
        chk("s1_done", 32'(done), 32'd1);
        chk("s1_idle", 32'(busy), 32'd0);
        chk("s1_hold_step", 32'(step_idx), 32'd1);
        step();
        chk("s1_done_once", 32'(done), 32'd0);

        // looping playback, then stop
        loop_en = 1'b1;
        pulse_start();
        expect_run("s2_n0", 8, 32'd1000, 1'b1, 4'd0);
        expect_run("s2_g0", 4, 32'd0, 1'b1, 4'd0);
        expect_run("s2_n1", 4, 32'd2000, 1'b1, 4'd1);
        expect_run("s2_g1", 4, 32'd0, 1'b1, 4'd1);
        expect_run("s2_loop", 8, 32'd1000, 1'b1, 4'd0);
        stop = 1'b1;
        step();
        stop = 1'b0;
        loop_en = 1'b0;
        chk("s2_stop_busy", 32'(busy), 32'd0);
        chk("s2_stop_step", 32'(step_idx), 32'd0);

        // stop during cycle 3 of note 0
        pulse_start();
        step();
        step();
        chk("s3_pre_period", period_cycles, 32'd1000);
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk("s3_period", period_cycles, 32'd0);
        chk("s3_busy", 32'(busy), 32'd0);
        chk("s3_done", 32'(done), 32'd0);
        step();
        chk("s3_done_late", 32'(done), 32'd0);

        // start and stop together in idle
        start = 1'b1;
        stop = 1'b1;
        step();
        start = 1'b0;
        stop = 1'b0;
        chk("s4_ss_busy", 32'(busy), 32'd0);
        chk("s4_ss_done", 32'(done), 32'd0);

        // write and start while busy are both ignored
        pulse_start();
        wr(4'd0, 32'd5555, 8'd7);
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            if (done) seen = 1'b1;
            else step();
        end
        chk("s4_done_seen", 32'(seen), 32'd1);
        step();
        chk("s4_no_restart", 32'(busy), 32'd0);
        pulse_start();
        expect_run("s4_rb", 8, 32'd1000, 1'b1, 4'd0);
        chk("s4_rb_gap", period_cycles, 32'd0);
        stop = 1'b1;
        step();
        stop = 1'b0;

        // empty sequence
        wr(4'd0, 32'd1234, 8'd0);
        pulse_start();
        chk("s5_done", 32'(done), 32'd1);
        chk("s5_busy", 32'(busy), 32'd0);
        step();
        chk("s5_done_once", 32'(done), 32'd0);
        chk("s5_busy2", 32'(busy), 32'd0);

        // full table at maximum duration
        for (int i = 0; i < 16; i++) begin
            wr(4'(i), 32'(100 + i), 8'd255);
        end
        pulse_start();
        cnt = 0;
        while (busy && cnt < 20000) begin
            cnt++;
            step();
        end
        chk("s6_busy_cycles", 32'(cnt), 32'd16384);
        chk("s6_done", 32'(done), 32'd1);
        chk("s6_last_step", 32'(step_idx), 32'd15);

        // reset mid-note silences output but keeps the table
        pulse_start();
        step();
        chk("s7_pre", period_cycles, 32'd100);
        reset = 1'b1;
        step();
        chk("s7_rst_period", period_cycles, 32'd0);
        chk("s7_rst_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        pulse_start();
        chk("s7_table_kept", period_cycles, 32'd100);
        stop = 1'b1;
        step();
        stop = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
